// File: rtl/count_lap_tracker_pkg.sv
// Shared definitions for the count lap tracker: event encodings, FSM states,
// the 10..40 counter range and the step classifier.
package count_lap_tracker_pkg;

  // Counter range, shared with the up/down counter that feeds this block.
  localparam logic [7:0] CNT_MIN = 8'd10;
  localparam logic [7:0] CNT_MAX = 8'd40;

  typedef enum logic [1:0] {
    EV_UP_WRAP    = 2'b00,
    EV_DOWN_WRAP  = 2'b01,
    EV_JUMP       = 2'b10,
    EV_DIR_CHANGE = 2'b11
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_UP_WRAP,
    STEP_DOWN_WRAP,
    STEP_JUMP
  } step_e;

  function automatic logic in_range(input logic [7:0] v);
    return (v >= CNT_MIN) && (v <= CNT_MAX);
  endfunction

  // Unit steps and wraps are only recognised between in-range values;
  // any other change is a jump.
  function automatic step_e classify_step(input logic [7:0] cur,
                                          input logic [7:0] prv);
    step_e s;
    if (cur == prv)                              s = STEP_HOLD;
    else if (!in_range(cur) || !in_range(prv))   s = STEP_JUMP;
    else if (prv == CNT_MAX && cur == CNT_MIN)   s = STEP_UP_WRAP;
    else if (prv == CNT_MIN && cur == CNT_MAX)   s = STEP_DOWN_WRAP;
    else if (cur == prv + 8'd1)                  s = STEP_UP;
    else if (cur + 8'd1 == prv)                  s = STEP_DOWN;
    else                                         s = STEP_JUMP;
    return s;
  endfunction

endpackage

// File: rtl/count_lap_tracker_slot.sv
// Single-entry valid/ready event holder. A push while a record is pending and
// not being accepted is dropped and raises the sticky ovf flag.
module lap_event_slot
  import count_lap_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic [1:0] push_type,
  input  logic [7:0] push_value,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] ev_type,
  output logic [7:0] ev_value,
  output logic       ovf
);

  logic hs;
  assign hs = valid && ready;

  // Record register: load when empty or being accepted, otherwise hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      ev_type  <= 2'b00;
      ev_value <= 8'd0;
    end else if (push && (!valid || hs)) begin
      valid    <= 1'b1;
      ev_type  <= push_type;
      ev_value <= push_value;
    end else if (hs) begin
      valid    <= 1'b0;
    end
  end

  // Sticky overflow: set on a lost push, cleared only by clr (clr wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         ovf <= 1'b0;
    else if (clr)                     ovf <= 1'b0;
    else if (push && valid && !ready) ovf <= 1'b1;
  end

endmodule

// File: rtl/count_lap_tracker.sv
// Count lap tracker: classifies each step of a 10..40 up/down counter, counts
// wraps in saturating totals and reports wrap/jump events through a one-entry
// valid/ready slot.
// Optional: define LAP_TRACKER_DIR_CHANGE_EN to also report direction changes.
module count_lap_tracker
  import count_lap_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       clr,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_type,
  output logic [7:0] ev_value,
  output logic [7:0] up_laps,
  output logic [7:0] down_laps,
  output logic       ovf
);

  state_e     state, state_nxt;
  logic [7:0] prev;
  step_e      step;
  logic       ev_gen;
  ev_type_e   ev_kind;
  logic       tracking;
  logic       push;
  logic       hs;

  assign step = classify_step(count, prev);
  assign hs   = ev_valid && ev_ready;

`ifdef LAP_TRACKER_DIR_CHANGE_EN
  logic dir_up;

  // Last direction: changed by unit steps and wraps only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dir_up <= 1'b1;
    else if (tracking) begin
      if (step == STEP_UP || step == STEP_UP_WRAP)          dir_up <= 1'b1;
      else if (step == STEP_DOWN || step == STEP_DOWN_WRAP) dir_up <= 1'b0;
    end
  end
`endif

  // Event selection from the step class; wraps take priority over direction.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ev_gen  = 1'b0;
    ev_kind = EV_JUMP;
    case (step)
      STEP_UP_WRAP:   begin ev_gen = 1'b1; ev_kind = EV_UP_WRAP;   end
      STEP_DOWN_WRAP: begin ev_gen = 1'b1; ev_kind = EV_DOWN_WRAP; end
      STEP_JUMP:      begin ev_gen = 1'b1; ev_kind = EV_JUMP;      end
`ifdef LAP_TRACKER_DIR_CHANGE_EN
      STEP_UP:        begin ev_gen = !dir_up; ev_kind = EV_DIR_CHANGE; end
      STEP_DOWN:      begin ev_gen = dir_up;  ev_kind = EV_DIR_CHANGE; end
`endif
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  state_nxt = ST_TRACK;
      ST_TRACK: if (push) state_nxt = ST_PEND;
      ST_PEND:  if (hs && !push) state_nxt = ST_TRACK;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: the INIT sample only seeds prev.
  always_comb begin
    tracking = (state != ST_INIT);
    push     = tracking && ev_gen;
  end

  // Previous sample register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 8'd0;
    else      prev <= count;
  end

  // Saturating lap totals; clr has priority over a same-cycle wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_laps   <= 8'd0;
      down_laps <= 8'd0;
    end else if (clr) begin
      up_laps   <= 8'd0;
      down_laps <= 8'd0;
    end else if (tracking) begin
      if (step == STEP_UP_WRAP && up_laps != 8'hFF)
        up_laps <= up_laps + 8'd1;
      if (step == STEP_DOWN_WRAP && down_laps != 8'hFF)
        down_laps <= down_laps + 8'd1;
    end
  end

  lap_event_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .push       (push),
    .push_type  (ev_kind),
    .push_value (count),
    .ready      (ev_ready),
    .valid      (ev_valid),
    .ev_type    (ev_type),
    .ev_value   (ev_value),
    .ovf        (ovf)
  );

endmodule

// File: tb/tb_count_lap_tracker.sv
// Self-checking bench for count_lap_tracker: directed scenarios plus a random
// counter walk, all compared against a behavioural model of the step rules.
module tb_count_lap_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       clr;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_type;
  logic [7:0] ev_value;
  logic [7:0] up_laps;
  logic [7:0] down_laps;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_init;
  int m_prev;
  bit m_dir_up;
  int m_up, m_down;
  bit m_ovf;
  bit m_valid;
  int m_type, m_value;

  always #5 clk = ~clk;

  count_lap_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .clr       (clr),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_type   (ev_type),
    .ev_value  (ev_value),
    .up_laps   (up_laps),
    .down_laps (down_laps),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit rng(input int v);
    return v >= 10 && v <= 40;
  endfunction

  task automatic model_reset();
    m_init = 1; m_prev = 0; m_dir_up = 1;
    m_up = 0; m_down = 0; m_ovf = 0;
    m_valid = 0; m_type = 0; m_value = 0;
  endtask

  // One clock: model prediction for inputs (c, cl, rdy), then compare.
  task automatic cyc(input int c, input bit cl, input bit rdy);
    int  d;
    int  ev;       // -1: no event, else event type
    bit  up_w, dn_w, up_s, dn_s;
    bit  hs;
    count = 8'(c); clr = cl; ev_ready = rdy;
    ev = -1; up_w = 0; dn_w = 0; up_s = 0; dn_s = 0;
    if (!m_init && c != m_prev) begin
      d = c - m_prev;
      if (rng(c) && rng(m_prev)) begin
        up_w = (m_prev == 40 && c == 10);
        dn_w = (m_prev == 10 && c == 40);
        up_s = (d == 1);
        dn_s = (d == -1);
      end
      if (up_w)                ev = 0;
      else if (dn_w)           ev = 1;
      else if (!up_s && !dn_s) ev = 2;
`ifdef LAP_TRACKER_DIR_CHANGE_EN
      else if (up_s != m_dir_up) ev = 3;
`endif
      if (up_w || up_s) m_dir_up = 1;
      if (dn_w || dn_s) m_dir_up = 0;
    end
    hs = m_valid && rdy;
    if (ev >= 0) begin
      if (!m_valid || hs) begin
        m_valid = 1; m_type = ev; m_value = c;
      end else m_ovf = 1;
    end else if (hs) m_valid = 0;
    if (cl) begin
      m_ovf = 0; m_up = 0; m_down = 0;
    end else begin
      if (up_w && m_up < 255)   m_up++;
      if (dn_w && m_down < 255) m_down++;
    end
    m_prev = c; m_init = 0;
    @(posedge clk); #1;
    check("ev_valid", ev_valid, m_valid);
    if (m_valid) begin
      check("ev_type", ev_type, m_type);
      check("ev_value", ev_value, m_value);
    end
    check("up_laps", up_laps, m_up);
    check("down_laps", down_laps, m_down);
    check("ovf", ovf, m_ovf);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic do_reset();
    rst = 1'b0; clr = 0; ev_ready = 0;
    #1;
    model_reset();
    check("rst_valid", ev_valid, 0);
    check("rst_type", ev_type, 0);
    check("rst_value", ev_value, 0);
    check("rst_up", up_laps, 0);
    check("rst_down", down_laps, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int cur;
  int r;

  initial begin
    rst = 1'b0; count = 0; clr = 0; ev_ready = 0;
    model_reset();
    @(negedge clk);

    // Up-wrap 38,39,40,10
    do_reset();
    cyc(38, 0, 0); cyc(39, 0, 0); cyc(40, 0, 0); cyc(10, 0, 0);
    check("upwrap_valid", ev_valid, 1);
    check("upwrap_type", ev_type, 0);
    check("upwrap_value", ev_value, 10);
    check("upwrap_laps", up_laps, 1);

    // Down-wrap 11,10,40 with ready high
    do_reset();
    cyc(11, 0, 1); cyc(10, 0, 1); cyc(40, 0, 1);
    check("dnwrap_type", ev_type, 1);
    check("dnwrap_value", ev_value, 40);
    check("dnwrap_laps", down_laps, 1);
    cyc(40, 0, 1);
    check("dnwrap_drain", ev_valid, 0);

    // Jump 20 -> 33
    do_reset();
    cyc(20, 0, 0); cyc(33, 0, 0);
    check("jump_type", ev_type, 2);
    check("jump_value", ev_value, 33);
    check("jump_up", up_laps, 0);
    check("jump_down", down_laps, 0);

    // Overflow with two wraps, then clr
    do_reset();
    cyc(39, 0, 0); cyc(40, 0, 0); cyc(10, 0, 0); cyc(40, 0, 0);
    check("ovf_type", ev_type, 0);
    check("ovf_value", ev_value, 10);
    check("ovf_set", ovf, 1);
    cyc(40, 1, 0);
    check("clr_ovf", ovf, 0);
    check("clr_up", up_laps, 0);
    check("clr_down", down_laps, 0);

    // clr beats a same-cycle wrap, but the event is still produced
    cyc(40, 0, 1); cyc(10, 1, 1);
    check("clrwrap_up", up_laps, 0);
    check("clrwrap_type", ev_type, 0);

    // Direction change 20,21,20
    do_reset();
    cyc(20, 0, 0); cyc(21, 0, 0); cyc(20, 0, 0);
`ifdef LAP_TRACKER_DIR_CHANGE_EN
    check("dir_valid", ev_valid, 1);
    check("dir_type", ev_type, 3);
    check("dir_value", ev_value, 20);
`else
    check("dir_none", ev_valid, 0);
`endif

    // Reset while an event is pending
    do_reset();
    cyc(39, 0, 0); cyc(40, 0, 0); cyc(10, 0, 0);
    do_reset();
    cyc(20, 0, 0); cyc(21, 0, 0);
    check("post_rst_valid", ev_valid, 0);

    // Saturation: 300 up-wraps (interleaved down-wraps saturate too)
    do_reset();
    cyc(40, 0, 1);
    for (int i = 0; i < 300; i++) begin
      cyc(10, 0, 1); cyc(40, 0, 1);
    end
    check("sat_up", up_laps, 255);
    check("sat_down", down_laps, 255);

    // Random counter walk
    do_reset();
    cur = 25;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (!rng(cur))    cur = $urandom_range(10, 40);
      else if (r < 45)  cur = (cur == 40) ? 10 : cur + 1;
      else if (r < 85)  cur = (cur == 10) ? 40 : cur - 1;
      else if (r < 92)  cur = cur;
      else              cur = $urandom_range(0, 60);
      cyc(cur, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
